gpmc_ring_reader: RTL and testbench

//  Fabric-side consumer of the GPMC dual-port SRAM (port B). The host fills a word

---
 rtl/gpmc_ring_reader.sv | 90 +++++++++
 tb/tb_gpmc_ring_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_ring_reader.sv
// Port-B consumer of the GPMC word ring: reads tail..head from the dual-port SRAM
// and streams the words out on valid/ready, publishing the committed tail pointer.
module gpmc_ring_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] host_head,
  input  logic              host_head_we,
  input  logic              flush,
  output logic              b_ena,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] tail_ptr,
  output logic [ADDR_W-1:0] words_avail,
  output logic              empty
);

  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_idx;
  logic              wr_idx;
  logic [1:0]        count;
  logic              pop;
  logic [ADDR_W-1:0] flush_head;

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  // A read may be issued into a full pipeline only if a word leaves this same cycle.
  assign b_ena   = (rd_ptr != head_q) && !flush
                   && (((count + {1'b0, inflight}) < 2'd2) || pop);
  assign b_addr  = rd_ptr;
  assign m_data  = m_valid ? fifo_mem[rd_idx] : '0;

  assign flush_head  = host_head_we ? host_head : head_q;
  assign words_avail = head_q - tail_ptr;
  assign empty       = (head_q == tail_ptr);

  // Control: pointers, in-flight flag and FIFO occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q   <= '0;
      rd_ptr   <= '0;
      tail_ptr <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_idx   <= 1'b0;
      wr_idx   <= 1'b0;
    end else begin
      if (host_head_we) head_q <= host_head;
      if (flush) begin
        rd_ptr   <= flush_head;
        tail_ptr <= flush_head;
        inflight <= 1'b0;
        count    <= 2'd0;
        rd_idx   <= 1'b0;
        wr_idx   <= 1'b0;
      end else begin
        inflight <= b_ena;
        if (b_ena)    rd_ptr <= rd_ptr + 1'b1;
        if (pop) begin
          tail_ptr <= tail_ptr + 1'b1;
          rd_idx   <= ~rd_idx;
        end
        if (inflight) wr_idx <= ~wr_idx;
        case ({inflight, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Data: returned SRAM word lands in the FIFO; storage needs no reset
  always_ff @(posedge clk) begin
    if (rst_n && !flush && inflight) fifo_mem[wr_idx] <= b_dout;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(inflight && !pop && count == 2'd2));
  end

endmodule

// File: tb/tb_gpmc_ring_reader.sv
// Bench for gpmc_ring_reader: SRAM model, queue-based reference of the word stream,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_gpmc_ring_reader;
  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] host_head = '0;
  logic          host_head_we = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          b_ena;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] tail_ptr;
  logic [AW-1:0] words_avail;
  logic          empty;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail = 0;

  gpmc_ring_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .host_head(host_head), .host_head_we(host_head_we),
    .flush(flush), .b_ena(b_ena), .b_addr(b_addr), .b_dout(b_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .tail_ptr(tail_ptr),
    .words_avail(words_avail), .empty(empty)
  );

  always #5 clk = ~clk;

  // Port-B SRAM: registered read, data valid the cycle after b_ena
  always @(posedge clk) if (b_ena) b_dout <= mem[b_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queue of words read but not yet consumed (front = next output)
  logic [DW-1:0] q[$];
  logic [AW-1:0] e_head = '0, e_tail = '0, e_rd = '0;
  bit            e_inf = 1'b0;
  bit            model_ok = 1'b0;

  always @(negedge clk) begin : mon
    logic          e_valid, e_pop, e_issue;
    logic [AW-1:0] nh;
    e_valid = (q.size() - int'(e_inf)) > 0;
    e_pop   = e_valid && m_ready;
    e_issue = (e_rd != e_head) && !flush && (q.size() < 2 || e_pop);
    if (model_ok) begin
      check("m_valid", m_valid, e_valid);
      if (e_valid) check("m_data", m_data, q[0]);
      check("b_ena", b_ena, e_issue);
      check("b_addr", b_addr, e_rd);
      check("tail_ptr", tail_ptr, e_tail);
      check("words_avail", words_avail, AW'(e_head - e_tail));
      check("empty", empty, e_head == e_tail);
      check("outstanding_le_2", q.size() <= 2, 1);
    end
    if (!rst_n) begin
      q.delete();
      e_head = '0; e_tail = '0; e_rd = '0; e_inf = 1'b0;
      model_ok = 1'b1;
    end else begin
      nh = host_head_we ? host_head : e_head;
      if (flush) begin
        q.delete();
        e_inf = 1'b0; e_tail = nh; e_rd = nh;
      end else begin
        if (e_pop) begin
          void'(q.pop_front());
          e_tail++;
        end
        if (e_issue) begin
          q.push_back(mem[e_rd]);
          e_rd++;
        end
        e_inf = e_issue;
      end
      e_head = nh;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] wa [4];
    logic [DW-1:0] w;
    bit            pat [9];
    wa  = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;

    // Power-on reset
    rst_n = 1'b0;
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_b_ena", b_ena, 0);
    check("rst_b_addr", b_addr, 0);
    check("rst_empty", empty, 1);
    check("rst_words_avail", words_avail, 0);
    rst_n = 1'b1;
    tick();

    // Basic four-word transfer
    for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + DW'(i);
    m_ready = 1'b1; host_head = 11'd4; host_head_we = 1'b1;
    tick();
    host_head_we = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (j <= 3) begin
        check("basic_b_ena", b_ena, 1);
        check("basic_b_addr", b_addr, j);
      end
      if (j >= 2 && j <= 5) begin
        w = 16'hA000 + DW'(j - 2);
        check("basic_m_valid", m_valid, 1);
        check("basic_m_data", m_data, w);
      end
      if (j == 6) begin
        check("basic_tail", tail_ptr, 4);
        check("basic_empty", empty, 1);
        check("basic_b_ena_idle", b_ena, 0);
      end
      tick();
    end

    // Backpressure over eight words
    for (int i = 4; i < 12; i++) mem[i] = 16'hC000 + DW'(i);
    host_head = 11'd12; host_head_we = 1'b1; m_ready = pat[0];
    tick();
    host_head_we = 1'b0;
    for (int c = 1; c < 80 && !(empty && !m_valid); c++) begin
      m_ready = pat[c % 9];
      tick();
    end
    check("bp_tail", tail_ptr, 12);
    check("bp_drained", empty, 1);

    // Wrap across the top of the address space
    m_ready = 1'b1; host_head = 11'd2046; host_head_we = 1'b1; flush = 1'b1;
    tick();
    host_head_we = 1'b0; flush = 1'b0;
    check("wrap_flush_tail", tail_ptr, 2046);
    mem[2046] = 16'hB000; mem[2047] = 16'hB001; mem[0] = 16'hB002; mem[1] = 16'hB003;
    host_head = 11'd2; host_head_we = 1'b1;
    tick();
    host_head_we = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (j <= 3) check("wrap_b_addr", b_addr, wa[j]);
      if (j >= 2 && j <= 5) begin
        w = 16'hB000 + DW'(j - 2);
        check("wrap_m_data", m_data, w);
      end
      if (j == 6) begin
        check("wrap_tail", tail_ptr, 2);
        check("wrap_words_avail", words_avail, 0);
      end
      tick();
    end

    // Flush mid-stream
    host_head = 11'd0; host_head_we = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b0; host_head = 11'd10;
    tick();
    host_head_we = 1'b0;
    tick(); tick();
    check("flush_pre_valid", m_valid, 1);
    check("flush_pre_avail", words_avail, 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_m_valid", m_valid, 0);
    check("flush_tail", tail_ptr, 10);
    check("flush_b_addr", b_addr, 10);
    check("flush_empty", empty, 1);
    check("flush_b_ena", b_ena, 0);
    m_ready = 1'b1;
    tick(); tick(); tick();
    check("flush_post_valid", m_valid, 0);
    check("flush_post_b_ena", b_ena, 0);

    // Head extended in the same cycle as a pop and a FIFO write
    for (int i = 0; i < 6; i++) mem[10 + i] = 16'hD000 + DW'(i);
    host_head = 11'd14; host_head_we = 1'b1;
    tick();
    host_head_we = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j >= 2 && j <= 7) begin
        w = 16'hD000 + DW'(j - 2);
        check("simul_m_valid", m_valid, 1);
        check("simul_m_data", m_data, w);
      end
      if (j == 3) check("simul_words_avail", words_avail, 5);
      if (j == 8) check("simul_tail", tail_ptr, 16);
      host_head_we = (j == 2);
      host_head = 11'd16;
      tick();
    end

    // Reset arriving mid-stream
    for (int i = 16; i < 20; i++) mem[i] = 16'hE000 + DW'(i);
    m_ready = 1'b0; host_head = 11'd20; host_head_we = 1'b1;
    tick();
    host_head_we = 1'b0;
    tick(); tick();
    check("mrst_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    tick(); tick();
    check("mrst_m_valid", m_valid, 0);
    check("mrst_tail", tail_ptr, 0);
    check("mrst_empty", empty, 1);
    check("mrst_b_ena", b_ena, 0);
    check("mrst_m_data", m_data, 0);
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (5) tick();
    check("mrst_post_valid", m_valid, 0);
    check("mrst_post_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
